instr_fetch_queue: RTL and testbench

//  Fetch-side prefetch queue upstream of the IF/RF pipe register in the 64-bit pipelined ARM CPU.

---
 rtl/instr_fetch_queue.sv | 126 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch-side prefetch queue in front of the IF/RF pipe register. Owns the
//   fetch PC, drives instruction memory, buffers {pc, instr} pairs in a
//   circular FIFO and hands them to RF under a valid/ready handshake. A taken
//   branch (redirect) flushes the queue and restarts fetch at the target.
//
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN
//     When defined, an empty queue forwards the memory word straight to the
//     outputs in the same cycle (zero-cycle latency).
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   imem_addr    out  fetch PC to instruction memory
//   imem_instr   in   instruction at imem_addr, same cycle
//   redirect_en  in   taken branch: flush and refetch from redirect_pc
//   redirect_pc  in   branch target, word aligned
//   out_valid    out  out_instr/out_pc hold a valid entry
//   out_ready    in   RF accepts the entry this cycle
//   out_instr    out  instruction at queue head
//   out_pc       out  PC of out_instr
//   count        out  occupied entries
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_en,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [63:0]   STEP_C  = 64'(PC_STEP);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [63:0]     fetch_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            bypass_take;
  logic            fifo_wr;
  logic            fifo_rd;

  assign imem_addr = fetch_pc;

  // Handshake, output selection and FIFO enables
  always_comb begin
    empty       = (count == '0);
    full        = (count == DEPTH_C);
    head        = mem[rd_ptr];
    out_valid   = !empty;
    // Storage is never cleared, so force the head to 0 while nothing is valid
    out_instr   = empty ? 32'h0 : head.instr;
    out_pc      = empty ? 64'h0 : head.pc;
    bypass_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && !redirect_en) begin
      out_valid   = 1'b1;
      out_instr   = imem_instr;
      out_pc      = fetch_pc;
      bypass_take = out_ready;
    end
`endif
    pop     = out_valid & out_ready;
    push    = !redirect_en & (!full | pop);
    // A bypassed word is consumed directly and never touches the FIFO
    fifo_wr = push & !bypass_take;
    fifo_rd = pop & !bypass_take;
  end

  // Fetch PC, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push)    fetch_pc <= fetch_pc + STEP_C;
      if (fifo_wr) wr_ptr   <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr   <= rd_ptr + AW'(1);
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  // Entry storage; not reset
  always_ff @(posedge clk) begin
    if (!reset && fifo_wr) begin
      mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_rd && empty));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  count;
  logic        imem_const;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc, input logic cmode);
    return cmode ? 32'h91000421 : (32'h91000421 ^ pc[31:0]);
  endfunction

  assign imem_instr = instr_of(imem_addr, imem_const);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [2:0]  e_cnt;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vt [21];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pc;
    int mc, pops, cyc;
    logic p, pu;

    // rst rdr rpc rdy | valid pc cnt addr
    vt[0]  = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   3'd0, 64'h0};
    vt[1]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd1, 64'h4};
    vt[2]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd2, 64'h8};
    vt[3]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd3, 64'hC};
    vt[4]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd4, 64'h10};
    vt[5]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd4, 64'h10};
    vt[6]  = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h0,   3'd4, 64'h10};
    vt[7]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   3'd4, 64'h14};
    vt[8]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   3'd4, 64'h18};
    vt[9]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'hC,   3'd4, 64'h1C};
    vt[10] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h10,  3'd4, 64'h20};
    vt[11] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h14,  3'd4, 64'h24};
    vt[12] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h18,  3'd4, 64'h28};
    vt[13] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h1C,  3'd4, 64'h2C};
    vt[14] = '{1'b0, 1'b1, 64'h100, 1'b0, 1'b0, 64'h0,   3'd0, 64'h100};
    vt[15] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h100, 3'd1, 64'h104};
    vt[16] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h100, 3'd2, 64'h108};
    vt[17] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 64'h100, 3'd3, 64'h10C};
    vt[18] = '{1'b0, 1'b1, 64'h40,  1'b1, 1'b0, 64'h0,   3'd0, 64'h40};
    vt[19] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h40,  3'd1, 64'h44};
    vt[20] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 64'h44,  3'd1, 64'h48};

    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b0; imem_const = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  imem_addr, 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_instr", 64'(out_instr), 64'h0);
    chk("rst_pc",    out_pc, 64'h0);

    // Streaming with a constant memory word
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_valid", 64'(out_valid), 64'h1);
      chk("stream_pc",    out_pc, 64'(i * 4));
      chk("stream_instr", 64'(out_instr), 64'h91000421);
    end

    // Table: fill to full, stream while full, redirects
    imem_const = 1'b0;
    for (int i = 0; i < 21; i++) begin
      reset = vt[i].rst; redirect_en = vt[i].rdr; redirect_pc = vt[i].rpc; out_ready = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].e_valid));
      chk($sformatf("v%0d_pc", i), out_pc, vt[i].e_pc);
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_instr", i), 64'(out_instr),
          vt[i].e_valid ? 64'(instr_of(vt[i].e_pc, 1'b0)) : 64'h0);
    end

    // Full queue, then reset together with redirect: reset wins
    redirect_en = 1'b0; out_ready = 1'b0;
    repeat (4) tick();
    chk("full_count", 64'(count), 64'd4);
    reset = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h80; out_ready = 1'b1;
    tick();
    chk("rstwin_addr",  imem_addr, 64'h0);
    chk("rstwin_count", 64'(count), 64'h0);
    chk("rstwin_valid", 64'(out_valid), 64'h0);
    reset = 1'b0; redirect_en = 1'b0;
    tick();
    chk("rstwin_first_pc",    out_pc, 64'h0);
    chk("rstwin_first_count", 64'(count), 64'd1);

    // Pointer wrap under random back-pressure, scoreboarded
    reset = 1'b1; tick(); reset = 1'b0;
    exp_pc = 64'h0; mc = 0; pops = 0; cyc = 0;
    while (pops < 10 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_valid", 64'(out_valid), 64'(mc != 0));
      p = out_valid && out_ready;
      if (p) begin
        chk("wrap_pc",    out_pc, exp_pc);
        chk("wrap_instr", 64'(out_instr), 64'(instr_of(exp_pc, 1'b0)));
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      pu = (mc < 4) || p;
      mc = mc + int'(pu) - int'(p);
      tick();
      chk("wrap_count", 64'(count), 64'(mc));
      cyc++;
    end
    chk("wrap_pops", 64'(pops), 64'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
